// File: rtl/aes_sbox_share_checker_pkg.sv
// Shared types and golden forward S-box for the masked S-box self-checker.
// The table is stored MSB-first: entry 0 sits in the top byte.
package aes_sbox_share_checker_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_t;

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sboxRef(input logic [7:0] x);
        return SBOX_TABLE[2047 - 8 * int'(x) -: 8];
    endfunction

endpackage

// File: rtl/aes_share_delay.sv
// Fixed-depth shift register carrying a valid bit and payload; DEPTH cycles.
// No backpressure: one entry shifts in per clock.
module aes_share_delay #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 8
) (
    input  logic             ClkxCI,
    input  logic             RstxBI,
    input  logic             ValidxSI,
    input  logic [WIDTH-1:0] DataxDI,
    output logic             ValidxSO,
    output logic [WIDTH-1:0] DataxDO
);

    logic [DEPTH-1:0] validxDP;
    logic [WIDTH-1:0] dataxDP [DEPTH];

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            validxDP <= '0;
        end else begin
            validxDP <= {validxDP[DEPTH-2:0], ValidxSI};
        end
    end

    // Payload needs no reset: it is only ever consumed alongside its valid bit.
    always_ff @(posedge ClkxCI) begin
        dataxDP[0] <= DataxDI;
        for (int i = 1; i < DEPTH; i++) begin
            dataxDP[i] <= dataxDP[i-1];
        end
    end

    assign ValidxSO = validxDP[DEPTH-1];
    assign DataxDO  = dataxDP[DEPTH-1];

endmodule

// File: rtl/aes_sbox_share_checker.sv
// Masks bytes into Boolean shares for a DOM S-box and checks the recombined result
// against a golden S-box LATENCY+1 cycles later; no backpressure, one compare per cycle.
module aes_sbox_share_checker
    import aes_sbox_share_checker_pkg::*;
#(
    parameter int SHARES  = 2,
    parameter int LATENCY = 5,
    parameter int CNT_W   = 16
) (
    input  logic                      ClkxCI,
    input  logic                      RstxBI,
    input  logic                      StartxSI,
    input  logic                      StopxSI,
    input  logic                      ValidxSI,
    input  logic [7:0]                XxDI,
    input  logic [8*(SHARES-1)-1:0]   MaskxDI,
    output logic [8*SHARES-1:0]       _XxDO,
    input  logic [8*SHARES-1:0]       _QxDI,
    output logic                      CheckValidxSO,
    output logic [7:0]                QxDO,
    output logic                      ErrorxSO,
    output logic [CNT_W-1:0]          ChkCntxDO,
    output logic [CNT_W-1:0]          ErrCntxDO,
    output logic [7:0]                FirstErrXxDO,
    output logic                      DonexSO
);

    localparam int DW = $clog2(LATENCY + 2);

    state_t                statexDP;
    logic [DW-1:0]         drainCntxDP;
    logic                  acceptxS;
    logic                  startxS;
    logic [8*SHARES-1:0]   sharesxD;
    logic [7:0]            qRecxD;
    logic                  dlyValidxS;
    logic [7:0]            dlyXxD;

    assign acceptxS = ValidxSI && (statexDP == StRun);
    assign startxS  = StartxSI && ((statexDP == StIdle) || (statexDP == StDone));

    always_comb begin
        logic [7:0] maskXor;
        maskXor  = '0;
        sharesxD = '0;
        for (int k = 1; k < SHARES; k++) begin
            sharesxD[8*k +: 8] = MaskxDI[8*(k-1) +: 8];
            maskXor            = maskXor ^ MaskxDI[8*(k-1) +: 8];
        end
        sharesxD[7:0] = XxDI ^ maskXor;
    end

    always_comb begin
        qRecxD = '0;
        for (int k = 0; k < SHARES; k++) begin
            qRecxD = qRecxD ^ _QxDI[8*k +: 8];
        end
    end

    // One extra stage over the S-box latency because _XxDO is itself registered.
    aes_share_delay #(
        .DEPTH (LATENCY + 1),
        .WIDTH (8)
    ) uDelay (
        .ClkxCI   (ClkxCI),
        .RstxBI   (RstxBI),
        .ValidxSI (acceptxS),
        .DataxDI  (XxDI),
        .ValidxSO (dlyValidxS),
        .DataxDO  (dlyXxD)
    );

    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            statexDP      <= StIdle;
            drainCntxDP   <= '0;
            _XxDO         <= '0;
            CheckValidxSO <= 1'b0;
            QxDO          <= '0;
            ErrorxSO      <= 1'b0;
            ChkCntxDO     <= '0;
            ErrCntxDO     <= '0;
            FirstErrXxDO  <= '0;
            DonexSO       <= 1'b0;
        end else begin
            _XxDO         <= acceptxS ? sharesxD : '0;
            CheckValidxSO <= 1'b0;

            unique case (statexDP)
                StIdle: begin
                    if (StartxSI) statexDP <= StRun;
                end
                StRun: begin
                    if (StopxSI) begin
                        statexDP    <= StDrain;
                        drainCntxDP <= DW'(LATENCY + 1);
                    end
                end
                StDrain: begin
                    drainCntxDP <= drainCntxDP - DW'(1);
                    if (drainCntxDP == DW'(1)) begin
                        statexDP <= StDone;
                        DonexSO  <= 1'b1;
                    end
                end
                StDone: begin
                    if (StartxSI) begin
                        statexDP <= StRun;
                        DonexSO  <= 1'b0;
                    end
                end
            endcase

            if (startxS) begin
                ChkCntxDO    <= '0;
                ErrCntxDO    <= '0;
                ErrorxSO     <= 1'b0;
                FirstErrXxDO <= '0;
            end else if (dlyValidxS) begin
                QxDO          <= qRecxD;
                CheckValidxSO <= 1'b1;
                if (ChkCntxDO != '1) ChkCntxDO <= ChkCntxDO + CNT_W'(1);
                if (qRecxD != sboxRef(dlyXxD)) begin
                    if (ErrCntxDO != '1) ErrCntxDO <= ErrCntxDO + CNT_W'(1);
                    // ErrorxSO still low means this is the first mismatch since Start.
                    if (!ErrorxSO) FirstErrXxDO <= dlyXxD;
                    ErrorxSO <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_aes_sbox_share_checker.sv
// Closed-loop bench: plays the masked S-box partner and checks the checker against a
// transaction-level model built on a GF(2^8) S-box.
module tb_aes_sbox_share_checker;

    localparam int SHARES  = 2;
    localparam int LATENCY = 5;
    localparam int CNT_W   = 16;
    localparam int CNT_W4  = 4;
    localparam int MW      = 8 * (SHARES - 1);

    logic              ClkxCI = 1'b0;
    logic              RstxBI = 1'b0;
    logic              StartxSI = 1'b0, StopxSI = 1'b0, ValidxSI = 1'b0;
    logic [7:0]        XxDI = '0;
    logic [MW-1:0]     MaskxDI = '0;
    logic [8*SHARES-1:0] xo, xo4;
    logic [8*SHARES-1:0] qi = '0;
    logic              chkV, chkV4, err, err4, done, done4;
    logic [7:0]        q, q4, fe, fe4;
    logic [CNT_W-1:0]  cc, ec;
    logic [CNT_W4-1:0] cc4, ec4;

    int tests = 0;
    int fails = 0;

    always #5 ClkxCI = ~ClkxCI;

    aes_sbox_share_checker #(.SHARES(SHARES), .LATENCY(LATENCY), .CNT_W(CNT_W)) udut (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartxSI), .StopxSI(StopxSI),
        .ValidxSI(ValidxSI), .XxDI(XxDI), .MaskxDI(MaskxDI), ._XxDO(xo), ._QxDI(qi),
        .CheckValidxSO(chkV), .QxDO(q), .ErrorxSO(err), .ChkCntxDO(cc), .ErrCntxDO(ec),
        .FirstErrXxDO(fe), .DonexSO(done)
    );

    aes_sbox_share_checker #(.SHARES(SHARES), .LATENCY(LATENCY), .CNT_W(CNT_W4)) udut4 (
        .ClkxCI(ClkxCI), .RstxBI(RstxBI), .StartxSI(StartxSI), .StopxSI(StopxSI),
        .ValidxSI(ValidxSI), .XxDI(XxDI), .MaskxDI(MaskxDI), ._XxDO(xo4), ._QxDI(qi),
        .CheckValidxSO(chkV4), .QxDO(q4), .ErrorxSO(err4), .ChkCntxDO(cc4), .ErrCntxDO(ec4),
        .FirstErrXxDO(fe4), .DonexSO(done4)
    );

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) v = {v[6:0], v[7]};
        return v;
    endfunction

    function automatic logic [7:0] sboxGf(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [8*SHARES-1:0] encode(input logic [7:0] x, input logic [MW-1:0] m);
        logic [8*SHARES-1:0] s = '0;
        logic [7:0] acc = x;
        for (int k = 1; k < SHARES; k++) begin
            s[8*k +: 8] = m[8*(k-1) +: 8];
            acc = acc ^ m[8*(k-1) +: 8];
        end
        s[7:0] = acc;
        return s;
    endfunction

    function automatic logic [7:0] recombine(input logic [8*SHARES-1:0] s);
        logic [7:0] acc = '0;
        for (int k = 0; k < SHARES; k++) acc = acc ^ s[8*k +: 8];
        return acc;
    endfunction

    function automatic int sat(input int v, input int w);
        int mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mode_t;
    mode_t mMode = M_IDLE;
    int cyc = 0, mDoneAt = 0, mChk = 0, mErr = 0;
    logic [8*SHARES-1:0] mXo = '0;
    logic mStrobe = 1'b0, mError = 1'b0;
    logic [7:0] mQ = '0, mFirst = '0;
    logic [7:0] pendX [int];
    bit flipAt [int];
    logic [8*SHARES-1:0] hist [int];
    bit faultX [256];
    bit faultAll = 1'b0;

    int tickNo = 0, strobeCnt = 0, firstT = 0, lastT = 0;
    logic [7:0] seenQ [256];

    task automatic modelReset();
        mMode = M_IDLE; mXo = '0; mStrobe = 1'b0; mError = 1'b0;
        mQ = '0; mFirst = '0; mChk = 0; mErr = 0;
        pendX.delete();
    endtask

    task automatic modelStep();
        logic [7:0] x, s;
        if (!RstxBI) begin
            modelReset();
            return;
        end
        cyc++;
        mStrobe = 1'b0;
        if (ValidxSI && mMode == M_RUN) begin
            mXo = encode(XxDI, MaskxDI);
            pendX[cyc + LATENCY + 1] = XxDI;
        end else begin
            mXo = '0;
        end
        if (StartxSI && (mMode == M_IDLE || mMode == M_DONE)) begin
            mMode = M_RUN; mChk = 0; mErr = 0; mError = 1'b0; mFirst = '0;
        end else begin
            if (pendX.exists(cyc)) begin
                x = pendX[cyc];
                s = sboxGf(x);
                mQ = s ^ ((flipAt.exists(cyc) && flipAt[cyc]) ? 8'h01 : 8'h00);
                mStrobe = 1'b1;
                mChk++;
                if (mQ != s) begin
                    mErr++;
                    if (!mError) mFirst = x;
                    mError = 1'b1;
                end
            end
            if (mMode == M_RUN && StopxSI) begin
                mMode = M_DRAIN;
                mDoneAt = cyc + LATENCY + 1;
            end else if (mMode == M_DRAIN && cyc == mDoneAt) begin
                mMode = M_DONE;
            end
        end
        if (pendX.exists(cyc)) pendX.delete(cyc);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkCycle();
        chk("XxDO", xo, mXo);
        chk("XxDO_w4", xo4, mXo);
        chk("CheckValid", chkV, mStrobe);
        chk("CheckValid_w4", chkV4, mStrobe);
        if (mStrobe) begin
            chk("QxDO", q, mQ);
            chk("QxDO_w4", q4, mQ);
        end
        chk("Error", err, mError);
        chk("Error_w4", err4, mError);
        chk("ChkCnt", cc, sat(mChk, CNT_W));
        chk("ChkCnt_w4", cc4, sat(mChk, CNT_W4));
        chk("ErrCnt", ec, sat(mErr, CNT_W));
        chk("ErrCnt_w4", ec4, sat(mErr, CNT_W4));
        chk("FirstErrX", fe, mFirst);
        chk("FirstErrX_w4", fe4, mFirst);
        chk("Done", done, mMode == M_DONE);
        chk("Done_w4", done4, mMode == M_DONE);
        if (chkV) begin
            if (strobeCnt == 0) firstT = tickNo;
            lastT = tickNo;
            seenQ[strobeCnt % 256] = q;
            strobeCnt++;
        end
    endtask

    // Acts as the masked S-box: LATENCY cycles after seeing _XxDO, present fresh output shares.
    task automatic driveQ();
        logic [8*SHARES-1:0] src, qv;
        logic [7:0] x, acc;
        bit flip;
        hist[cyc] = xo;
        src = hist.exists(cyc - LATENCY) ? hist[cyc - LATENCY] : '0;
        x = recombine(src);
        acc = sboxGf(x);
        qv = '0;
        for (int k = 1; k < SHARES; k++) begin
            qv[8*k +: 8] = 8'($urandom);
            acc = acc ^ qv[8*k +: 8];
        end
        qv[7:0] = acc;
        flip = faultAll || faultX[x];
        if (flip) qv[8] = ~qv[8];
        flipAt[cyc + 1] = flip;
        qi = qv;
    endtask

    task automatic tick();
        @(posedge ClkxCI);
        modelStep();
        @(negedge ClkxCI);
        tickNo++;
        checkCycle();
        driveQ();
    endtask

    task automatic setIn(input logic st, input logic sp, input logic v,
                         input logic [7:0] x, input logic [MW-1:0] m);
        StartxSI = st; StopxSI = sp; ValidxSI = v; XxDI = x; MaskxDI = m;
    endtask

    function automatic logic [MW-1:0] rndMask();
        return MW'($urandom);
    endfunction

    task automatic waitDone(input string name, output int j);
        j = 0;
        while (!done && j < 50) begin
            tick();
            j++;
        end
        chk(name, done, 1'b1);
    endtask

    initial begin
        int j;
        // Pin the reference S-box against known table values.
        chk("sbox_00", sboxGf(8'h00), 8'h63);
        chk("sbox_01", sboxGf(8'h01), 8'h7c);
        chk("sbox_10", sboxGf(8'h10), 8'hca);
        chk("sbox_20", sboxGf(8'h20), 8'hb7);
        chk("sbox_53", sboxGf(8'h53), 8'hed);
        chk("sbox_ff", sboxGf(8'hff), 8'h16);

        repeat (3) tick();
        #2 RstxBI = 1'b1;
        tick();

        // Single transaction.
        setIn(1, 0, 0, 8'h00, '0); tick();
        setIn(0, 0, 1, 8'h00, MW'(8'hA5)); tick();
        chk("t1_XxDO", xo, {SHARES{8'hA5}});
        setIn(0, 0, 0, 8'h00, '0);
        repeat (LATENCY + 1) tick();
        chk("t1_strobe", chkV, 1'b1);
        chk("t1_QxDO", q, 8'h63);
        chk("t1_ChkCnt", cc, 1);
        chk("t1_Error", err, 1'b0);
        setIn(0, 1, 0, 8'h00, '0); tick();
        setIn(0, 0, 0, 8'h00, '0);
        waitDone("t1_done", j);

        // Full sweep back-to-back.
        setIn(1, 0, 0, 8'h00, '0); tick();
        strobeCnt = 0;
        for (int i = 0; i < 256; i++) begin
            setIn(0, 0, 1, i[7:0], rndMask());
            tick();
        end
        setIn(0, 1, 0, 8'h00, '0); tick();
        setIn(0, 0, 0, 8'h00, '0);
        waitDone("sweep_done", j);
        chk("sweep_drain_cycles", j, LATENCY + 1);
        chk("sweep_strobes", strobeCnt, 256);
        chk("sweep_span", lastT - firstT, 255);
        chk("sweep_q00", seenQ[8'h00], 8'h63);
        chk("sweep_q53", seenQ[8'h53], 8'hed);
        chk("sweep_qff", seenQ[8'hff], 8'h16);
        chk("sweep_ChkCnt", cc, 256);
        chk("sweep_ErrCnt", ec, 0);

        // Injected faults on share 1.
        faultX[8'h10] = 1'b1;
        faultX[8'h20] = 1'b1;
        setIn(1, 0, 0, 8'h00, '0); tick();
        setIn(0, 0, 1, 8'h10, rndMask()); tick();
        setIn(0, 0, 0, 8'h00, '0);
        repeat (LATENCY + 1) tick();
        chk("f1_Error", err, 1'b1);
        chk("f1_ErrCnt", ec, 1);
        chk("f1_First", fe, 8'h10);
        setIn(0, 0, 1, 8'h20, rndMask()); tick();
        setIn(0, 0, 0, 8'h00, '0);
        repeat (LATENCY + 1) tick();
        chk("f2_ErrCnt", ec, 2);
        chk("f2_First", fe, 8'h10);
        setIn(0, 1, 0, 8'h00, '0); tick();
        setIn(0, 0, 0, 8'h00, '0);
        waitDone("f_done", j);
        faultX[8'h10] = 1'b0;
        faultX[8'h20] = 1'b0;

        // Stop together with Valid.
        setIn(1, 0, 0, 8'h00, '0); tick();
        setIn(0, 1, 1, 8'h01, rndMask()); tick();
        setIn(0, 0, 1, 8'h02, rndMask()); tick();
        chk("sv_XxDO_ignored", xo, 0);
        setIn(0, 0, 0, 8'h00, '0);
        repeat (LATENCY) tick();
        chk("sv_strobe", chkV, 1'b1);
        chk("sv_QxDO", q, 8'h7c);
        chk("sv_ChkCnt", cc, 1);
        chk("sv_done", done, 1'b1);
        tick();
        chk("sv_no_extra", chkV, 1'b0);

        // Saturation in the narrow-counter instance.
        faultAll = 1'b1;
        setIn(1, 0, 0, 8'h00, '0); tick();
        for (int i = 0; i < 20; i++) begin
            setIn(0, 0, 1, 8'($urandom), rndMask());
            tick();
        end
        setIn(0, 1, 0, 8'h00, '0); tick();
        setIn(0, 0, 0, 8'h00, '0);
        waitDone("sat_done", j);
        faultAll = 1'b0;
        chk("sat_ErrCnt_w4", ec4, 15);
        chk("sat_ChkCnt_w4", cc4, 15);
        chk("sat_ErrCnt_w16", ec, 20);
        setIn(1, 0, 0, 8'h00, '0); tick();
        setIn(0, 0, 0, 8'h00, '0);
        chk("restart_ChkCnt_w4", cc4, 0);
        chk("restart_ErrCnt_w4", ec4, 0);
        chk("restart_Error_w4", err4, 1'b0);

        // Reset with entries in flight.
        for (int i = 0; i < 3; i++) begin
            setIn(0, 0, 1, 8'($urandom), rndMask());
            tick();
        end
        setIn(0, 0, 0, 8'h00, '0);
        #2 RstxBI = 1'b0;
        modelReset();
        #1;
        chk("rst_XxDO", xo, 0);
        chk("rst_QxDO", q, 0);
        chk("rst_ChkCnt", cc, 0);
        chk("rst_ErrCnt", ec, 0);
        chk("rst_Done", done, 1'b0);
        tick();
        #2 RstxBI = 1'b1;
        strobeCnt = 0;
        repeat (LATENCY + 4) tick();
        chk("rst_no_strobe", strobeCnt, 0);
        setIn(0, 0, 1, 8'h33, rndMask()); tick();
        chk("rst_idle_ignores_valid", xo, 0);
        setIn(0, 0, 0, 8'h00, '0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
